// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end: scancodes, key_state
// bit positions, frame FSM encoding and the scancode-to-bitmap lookup.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam int KS_WIDTH    = 12;
  localparam int KS_LP_LEFT  = 0;
  localparam int KS_LP_RIGHT = 1;
  localparam int KS_LP_UP    = 2;
  localparam int KS_LP_DOWN  = 3;
  localparam int KS_LP_SHIFT = 4;
  localparam int KS_LP_SPACE = 5;
  localparam int KS_RP_LEFT  = 6;
  localparam int KS_RP_RIGHT = 7;
  localparam int KS_RP_UP    = 8;
  localparam int KS_RP_DOWN  = 9;
  localparam int KS_RP_ENTER = 10;
  localparam int KS_RP_SHIFT = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // One-hot key_state position for a key event; all zero for unmapped codes,
  // which is why E0 12 / E0 59 never reach the shift bits.
  function automatic logic [KS_WIDTH-1:0] key_mask(input logic ext, input logic [7:0] code);
    key_mask = '0;
    if (!ext) begin
      case (code)
        SC_A:      key_mask[KS_LP_LEFT]  = 1'b1;
        SC_D:      key_mask[KS_LP_RIGHT] = 1'b1;
        SC_W:      key_mask[KS_LP_UP]    = 1'b1;
        SC_S:      key_mask[KS_LP_DOWN]  = 1'b1;
        SC_LSHIFT: key_mask[KS_LP_SHIFT] = 1'b1;
        SC_SPACE:  key_mask[KS_LP_SPACE] = 1'b1;
        SC_ENTER:  key_mask[KS_RP_ENTER] = 1'b1;
        SC_RSHIFT: key_mask[KS_RP_SHIFT] = 1'b1;
        default:   key_mask = '0;
      endcase
    end else begin
      case (code)
        SC_LEFT:  key_mask[KS_RP_LEFT]  = 1'b1;
        SC_RIGHT: key_mask[KS_RP_RIGHT] = 1'b1;
        SC_UP:    key_mask[KS_RP_UP]    = 1'b1;
        SC_DOWN:  key_mask[KS_RP_DOWN]  = 1'b1;
        default:  key_mask = '0;
      endcase
    end
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length debounce for a PS/2 line; emits a
// one-cycle pulse when the filtered level falls.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic          sync_a;
  logic          sync_b;
  logic          filtered;
  logic [CW-1:0] run_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Any sample that agrees with the filtered level restarts the run, so short glitches never flip it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filtered <= 1'b1;
      run_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync_b == filtered) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        filtered <= sync_b;
        run_cnt  <= '0;
        fall     <= filtered;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: frame deframing, E0/F0 prefix handling, key
// events and the held-key bitmap for both players.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CLK_FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                clk_50MHz,
  input  logic                rst,
  input  logic                PS2Clk,
  input  logic                PS2Data,
  output logic [7:0]          scancode,
  output logic                scancode_valid,
  output logic                extended,
  output logic                released,
  output logic                frame_err,
  output logic [KS_WIDTH-1:0] key_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t          state;
  ps2_state_t          next_state;
  logic                clk_fall;
  logic                data_meta;
  logic                data_sync;
  logic [7:0]          shift_reg;
  logic [2:0]          bit_cnt;
  logic                parity_bit;
  logic [TW-1:0]       to_cnt;
  logic                ext_pending;
  logic                brk_pending;
  logic                timeout_hit;
  logic                shift_en;
  logic                parity_en;
  logic                frame_ok;
  logic                frame_bad;
  logic [KS_WIDTH-1:0] event_mask;

  ps2_line_filter #(
    .FILTER_LEN(CLK_FILTER_LEN)
  ) u_clk_filter (
    .clk  (clk_50MHz),
    .rst  (rst),
    .raw  (PS2Clk),
    .fall (clk_fall)
  );

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= PS2Data;
      data_sync <= data_meta;
    end
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (timeout_hit) begin
      next_state = IDLE;
    end else if (clk_fall) begin
      case (state)
        IDLE:    if (!data_sync) next_state = DATA;
        DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
        PARITY:  next_state = STOP;
        STOP:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Frame acceptance needs a high stop bit and odd parity over data plus parity.
  always_comb begin
    timeout_hit = (state != IDLE) && !clk_fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    shift_en    = clk_fall && (state == DATA);
    parity_en   = clk_fall && (state == PARITY);
    frame_ok    = clk_fall && (state == STOP) && data_sync && ((^shift_reg) ^ parity_bit);
    frame_bad   = clk_fall && (state == STOP) && !frame_ok;
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
    end else begin
      if (clk_fall && state == IDLE) bit_cnt <= '0;
      else if (shift_en)             bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)  shift_reg  <= {data_sync, shift_reg[7:1]};
      if (parity_en) parity_bit <= data_sync;
      if (state == IDLE || clk_fall || timeout_hit) to_cnt <= '0;
      else                                           to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      scancode       <= '0;
      scancode_valid <= 1'b0;
      extended       <= 1'b0;
      released       <= 1'b0;
      frame_err      <= 1'b0;
      ext_pending    <= 1'b0;
      brk_pending    <= 1'b0;
    end else begin
      scancode_valid <= 1'b0;
      frame_err      <= 1'b0;
      if (timeout_hit || frame_bad) begin
        frame_err   <= 1'b1;
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (frame_ok) begin
        if (shift_reg == SC_EXT) begin
          ext_pending <= 1'b1;
        end else if (shift_reg == SC_BRK) begin
          brk_pending <= 1'b1;
        end else begin
          scancode       <= shift_reg;
          extended       <= ext_pending;
          released       <= brk_pending;
          scancode_valid <= 1'b1;
          ext_pending    <= 1'b0;
          brk_pending    <= 1'b0;
        end
      end
    end
  end

  // The bitmap follows the registered event, so it settles one cycle after the valid pulse.
  assign event_mask = key_mask(extended, scancode);

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      key_state <= '0;
    end else if (scancode_valid) begin
      key_state <= released ? (key_state & ~event_mask) : (key_state | event_mask);
    end
  end

endmodule
